// File: rtl/stream_sink_checker.sv
// stream_sink_checker
//   Initiator end of the req/ack pull protocol. The block raises a request,
//   takes one word per acknowledged request and checks that word against an
//   affine golden sequence:
//     expected_k = EXP_MUL * (SEQ_INIT + k*SEQ_STEP) + EXP_ADD  (mod 2^DATA_WIDTH)
//   It also reports statistics, a done flag and a watchdog timeout.
//   It can be used as a simulation consumer, and it is synthesizable for on-chip test.
//
// Ports
//   i_clk              rising-edge clock
//   i_rst_n            synchronous reset, active low
//   i_en               1 = issue requests, 0 = pause (req drops on the next edge)
//   o_req              request to the responder (registered)
//   i_ack              acknowledge from the responder; i_din is valid while it is high
//   i_din              data from the responder
//   o_count            accepted words (saturating)
//   o_err_count        accepted words that mismatched the golden model (saturating)
//   o_first_err_idx    index k of the first mismatch, all-ones if none
//   o_first_err_data   word captured at the first mismatch, 0 if none
//   o_last_data        most recently accepted word
//   o_max_gap          largest number of cycles between consecutive accepted words
//   o_spurious         acks seen while req was low (saturating)
//   o_mismatch         one-cycle pulse after a mismatching transfer
//   o_done             sticky: MAX_COUNT words accepted
//   o_timeout          sticky: req stayed high TIMEOUT_CYC cycles without an ack
module stream_sink_checker #(
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] SEQ_INIT    = DATA_WIDTH'(32'd0),
  parameter logic [DATA_WIDTH-1:0] SEQ_STEP    = DATA_WIDTH'(32'd1),
  parameter logic [DATA_WIDTH-1:0] EXP_MUL     = DATA_WIDTH'(32'd1),
  parameter logic [DATA_WIDTH-1:0] EXP_ADD     = DATA_WIDTH'(32'd0),
  parameter int unsigned           MAX_COUNT   = 5000,
  parameter int unsigned           TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_en,
  output logic                  o_req,
  input  logic                  i_ack,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [31:0]           o_count,
  output logic [31:0]           o_err_count,
  output logic [31:0]           o_first_err_idx,
  output logic [DATA_WIDTH-1:0] o_first_err_data,
  output logic [DATA_WIDTH-1:0] o_last_data,
  output logic [31:0]           o_max_gap,
  output logic [31:0]           o_spurious,
  output logic                  o_mismatch,
  output logic                  o_done,
  output logic                  o_timeout
);

  // The per-word increment of the expected value is a constant, so the golden
  // model costs one adder and no multiplier.
  localparam logic [DATA_WIDTH-1:0] EXP_INC  = DATA_WIDTH'(EXP_MUL * SEQ_STEP);
  localparam logic [DATA_WIDTH-1:0] EXP_INIT = DATA_WIDTH'(EXP_MUL * SEQ_INIT + EXP_ADD);
  localparam logic [31:0]           LAST_IDX = 32'(MAX_COUNT - 32'd1);
  localparam logic [31:0]           WD_LAST  = 32'(TIMEOUT_CYC - 32'd1);
  localparam logic [31:0]           ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_req;
  logic                  w_req_next;
  logic [31:0]           r_count;
  logic [31:0]           r_err_count;
  logic [31:0]           r_first_err_idx;
  logic [DATA_WIDTH-1:0] r_first_err_data;
  logic [DATA_WIDTH-1:0] r_last_data;
  logic [DATA_WIDTH-1:0] r_expected;
  logic [31:0]           r_max_gap;
  logic [31:0]           r_gap;
  logic [31:0]           r_spurious;
  logic [31:0]           r_wd;
  logic                  r_mismatch;
  logic                  r_done;
  logic                  r_timeout;

  logic w_xfer;
  logic w_spur;
  logic w_last_word;
  logic w_wd_expire;
  logic w_din_bad;

  // Saturating 32-bit increment shared by all statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    if (v == ALL_ONES) begin
      sat_inc = v;
    end else begin
      sat_inc = v + 32'd1;
    end
  endfunction

  // A transfer needs the registered request, so an ack with req low is only counted as spurious.
  assign w_xfer      = r_req & i_ack;
  assign w_spur      = ~r_req & i_ack;
  assign w_last_word = w_xfer & (r_count == LAST_IDX);
  assign w_wd_expire = (r_state == ST_REQ) & ~i_ack & (r_wd == WD_LAST);
  assign w_din_bad   = (i_din != r_expected);

  // State and request register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_req   <= w_req_next;
    end
  end

  // Next-state logic. An ack wins over en falling in the same cycle.
  // HOLD forces one low-request cycle after every transfer.
  always_comb begin
    w_state_next = r_state;
    w_req_next   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_en & ~r_done & ~r_timeout) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (w_last_word) begin
          w_state_next = ST_STOP;
        end else if (i_ack) begin
          w_state_next = ST_HOLD;
        end else if (w_wd_expire) begin
          w_state_next = ST_STOP;
        end else if (!i_en) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      ST_HOLD: begin
        if (i_en & ~r_done) begin
          w_state_next = ST_REQ;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_STOP: begin
        w_state_next = ST_STOP;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (w_state_next == ST_REQ) begin
      w_req_next = 1'b1;
    end else begin
      w_req_next = 1'b0;
    end
  end

  // Transfer capture, golden-model check, statistics, watchdog and sticky flags
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_count          <= 32'd0;
      r_err_count      <= 32'd0;
      r_first_err_idx  <= ALL_ONES;
      r_first_err_data <= {DATA_WIDTH{1'b0}};
      r_last_data      <= {DATA_WIDTH{1'b0}};
      r_expected       <= EXP_INIT;
      r_max_gap        <= 32'd0;
      r_gap            <= 32'd0;
      r_spurious       <= 32'd0;
      r_wd             <= 32'd0;
      r_mismatch       <= 1'b0;
      r_done           <= 1'b0;
      r_timeout        <= 1'b0;
    end else begin
      r_mismatch <= 1'b0;
      if (w_xfer) begin
        r_count     <= sat_inc(r_count);
        r_last_data <= i_din;
        r_expected  <= r_expected + EXP_INC;
        // The gap register holds the cycles since the previous transfer before this edge.
        r_max_gap   <= (r_gap > r_max_gap) ? r_gap : r_max_gap;
        r_gap       <= 32'd1;
        if (w_din_bad) begin
          r_err_count <= sat_inc(r_err_count);
          r_mismatch  <= 1'b1;
          if (r_first_err_idx == ALL_ONES) begin
            r_first_err_idx  <= r_count;
            r_first_err_data <= i_din;
          end
        end
      end else begin
        r_gap <= sat_inc(r_gap);
      end
      if (w_spur) begin
        r_spurious <= sat_inc(r_spurious);
      end
      if (w_last_word) begin
        r_done <= 1'b1;
      end
      if (w_wd_expire) begin
        r_timeout <= 1'b1;
      end
      // The watchdog only runs while the request stays up and unanswered.
      if ((r_state == ST_REQ) && (w_state_next == ST_REQ)) begin
        r_wd <= sat_inc(r_wd);
      end else begin
        r_wd <= 32'd0;
      end
    end
  end

  assign o_req            = r_req;
  assign o_count          = r_count;
  assign o_err_count      = r_err_count;
  assign o_first_err_idx  = r_first_err_idx;
  assign o_first_err_data = r_first_err_data;
  assign o_last_data      = r_last_data;
  assign o_max_gap        = r_max_gap;
  assign o_spurious       = r_spurious;
  assign o_mismatch       = r_mismatch;
  assign o_done           = r_done;
  assign o_timeout        = r_timeout;

endmodule
